wfg_core_burst: RTL
===================

// Module: wfg_core_burst
// PURPOSE
//  Parametrised pattern-timing core for the waveform generator. Generates the
//  subcycle and sync pulse trains that pace the downstream pattern/drive
//  blocks. Adds configurable counter widths, continuous or burst mode
//  (stop after N sync periods), and sync-period counter/done outputs.
// PARAMETERS
//  SUB_W   16  width of subcycle threshold/counter
//  SYNC_W   8  width of sync threshold and subcycle index
//  BURST_W  8  width of burst length and sync-period counter
// PORTS
//  clk                     in   1        system clock
//  rst                     in   1        async reset, active-high
//  en_i                    in   1        enable; level-sensitive
//  wfg_subcycle_count_i    in   SUB_W    N: subcycle period = N+1 clk
//  wfg_sync_count_i        in   SYNC_W   S: sync period = S+1 subcycles
//  wfg_burst_len_i         in   BURST_W  B: syncs per burst; 0 = continuous
//  wfg_pat_start_o         out  1        1-clk pulse, first cycle of RUN
//  wfg_pat_subcycle_o      out  1        1-clk subcycle pulse
//  wfg_pat_sync_o          out  1        1-clk sync pulse
//  wfg_pat_subcycle_cnt_o  out  SYNC_W   subcycle index in sync period
//  wfg_pat_sync_cnt_o      out  BURST_W  sync pulses issued in this run
//  wfg_pat_done_o          out  1        1-clk pulse on last sync of burst
//  active_o                out  1        high while state == RUN
// BEHAVIOUR
//  Clock/reset: one clock, clk; rst is asynchronous, active-high. Reset
//   clears state to IDLE; all counters/shadows 0; every output 0 immediately.
//  FSM: IDLE, RUN, HOLD.
//   IDLE->RUN: en_i=1 at an edge. Load sub_cnt<=N, S_sh<=S, B_sh<=B,
//    sub_idx<=0, sync_cnt<=0. First RUN cycle = T; start_o=1 only in T.
//   RUN->IDLE: en_i=0 at an edge (priority over all else). Counters cleared;
//    no done. Pulses already in that cycle still complete.
//   RUN->HOLD: edge ending the cycle in which done_o=1.
//   HOLD->IDLE: en_i=0. HOLD: all pulses 0, active_o=0, counts frozen.
//    Re-arm requires en_i low then high.
//  Subcycle: in RUN, subcycle_o = (sub_cnt==0), combinational from regs.
//   sub_cnt decrements each cycle; at 0, reloads from live
//   wfg_subcycle_count_i. Pulses at T+N, T+2N+1, ...; N=0 -> every cycle.
//  Index: on each subcycle pulse, sub_idx<=(sub_idx==S_sh) ? 0 : sub_idx+1.
//  Sync: sync_o = subcycle_o & (sub_idx==S_sh). On wrap, S_sh reloads from
//   live wfg_sync_count_i; period changes apply only at sync boundaries.
//   First sync at T+(S+1)(N+1)-1.
//  Burst count: sync_cnt increments on each sync pulse; saturates at
//   2^BURST_W-1 in continuous mode (never wraps).
//  Done: B_sh!=0 & sync_o & (sync_cnt==B_sh-1) -> done_o=1 same cycle
//   as that sync pulse. B sampled only at IDLE->RUN.
//  Outputs subcycle_cnt_o=sub_idx, sync_cnt_o=sync_cnt; hold last value
//   in HOLD; 0 in IDLE.
//  Latency: start_o 1 clk after en_i sampled high; no handshake/backpressure.
//  Config changes mid-period never truncate the running count.
// TESTING
//  Continuous: N=3,S=2,B=0, en_i high -> start_o @T; subcycle_o @T+3,
//   T+7, T+11; sync_o @T+11, T+23; subcycle_cnt_o 0,1,2,0.
//  Burst: N=3,S=2,B=2 -> sync_o @T+11, T+23; done_o @T+23; active_o low
//   from T+24; no pulses while en_i held; en_i low->high restarts start_o.
//  Degenerate: N=0,S=0,B=0 -> subcycle_o and sync_o high every RUN cycle;
//   sync_cnt_o increments each clk and saturates at 255.
//  Abort: en_i low at T+5 of N=3,S=2 run -> IDLE next edge; outputs 0;
//   no done_o; re-enable restarts from index 0.
//  Async reset at T+9 mid-run (not at clk edge) -> all outputs 0 at once;
//   after release with en_i high -> fresh start_o.
//  Reconfig: change S 2->1 at T+5 -> period 3 kept until sync @T+11,
//   next sync @T+19.

Source files
------------

// File: rtl/wfg_core_burst.sv
// Pattern-timing core for the waveform generator.
// Produces the subcycle and sync pulse trains that pace the downstream
// pattern/drive blocks. Runs continuously, or as a burst that stops after
// a programmed number of sync periods and then parks until en_i is cycled.
module wfg_core_burst #(
    parameter int SUB_W   = 16,
    parameter int SYNC_W  = 8,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [SUB_W-1:0]   wfg_subcycle_count_i,
    input  logic [SYNC_W-1:0]  wfg_sync_count_i,
    input  logic [BURST_W-1:0] wfg_burst_len_i,
    output logic               wfg_pat_start_o,
    output logic               wfg_pat_subcycle_o,
    output logic               wfg_pat_sync_o,
    output logic [SYNC_W-1:0]  wfg_pat_subcycle_cnt_o,
    output logic [BURST_W-1:0] wfg_pat_sync_cnt_o,
    output logic               wfg_pat_done_o,
    output logic               active_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SUB_W-1:0]   sub_cnt_q,  sub_cnt_d;
    logic [SYNC_W-1:0]  s_sh_q,     s_sh_d;
    logic [BURST_W-1:0] b_sh_q,     b_sh_d;
    logic [SYNC_W-1:0]  sub_idx_q,  sub_idx_d;
    logic [BURST_W-1:0] sync_cnt_q, sync_cnt_d;
    logic               start_q,    start_d;

    logic run;
    logic subcycle;
    logic sync;
    logic done;

    // State register; reset forces IDLE so every output drops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping en_i always wins over burst completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (en_i) state_d = RUN;
            RUN: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if (done) begin
                    state_d = HOLD;
                end
            end
            HOLD: if (!en_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; all pulses come from registers only, never from inputs.
    always_comb begin
        run                    = (state_q == RUN);
        subcycle               = run && (sub_cnt_q == '0);
        sync                   = subcycle && (sub_idx_q == s_sh_q);
        done                   = sync && (b_sh_q != '0) &&
                                 (sync_cnt_q == b_sh_q - BURST_W'(1));
        active_o               = run;
        wfg_pat_start_o        = run && start_q;
        wfg_pat_subcycle_o     = subcycle;
        wfg_pat_sync_o         = sync;
        wfg_pat_done_o         = done;
        wfg_pat_subcycle_cnt_o = (state_q == IDLE) ? '0 : sub_idx_q;
        wfg_pat_sync_cnt_o     = (state_q == IDLE) ? '0 : sync_cnt_q;
    end

    // Datapath next-state: counters load on entry to RUN, clear on exit to
    // IDLE, and freeze in HOLD. Period shadows only reload at boundaries so
    // a config change never truncates a period already in flight.
    always_comb begin
        sub_cnt_d  = sub_cnt_q;
        s_sh_d     = s_sh_q;
        b_sh_d     = b_sh_q;
        sub_idx_d  = sub_idx_q;
        sync_cnt_d = sync_cnt_q;
        start_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_i) begin
                    sub_cnt_d  = wfg_subcycle_count_i;
                    s_sh_d     = wfg_sync_count_i;
                    b_sh_d     = wfg_burst_len_i;
                    start_d    = 1'b1;
                end else begin
                    sub_cnt_d  = '0;
                    s_sh_d     = '0;
                    b_sh_d     = '0;
                end
                sub_idx_d  = '0;
                sync_cnt_d = '0;
            end
            RUN: begin
                if (!en_i) begin
                    sub_cnt_d  = '0;
                    s_sh_d     = '0;
                    b_sh_d     = '0;
                    sub_idx_d  = '0;
                    sync_cnt_d = '0;
                end else begin
                    sub_cnt_d = subcycle ? wfg_subcycle_count_i
                                         : sub_cnt_q - SUB_W'(1);
                    if (subcycle) begin
                        if (sub_idx_q == s_sh_q) begin
                            sub_idx_d = '0;
                            s_sh_d    = wfg_sync_count_i;
                        end else begin
                            sub_idx_d = sub_idx_q + SYNC_W'(1);
                        end
                    end
                    if (sync && (sync_cnt_q != '1)) begin
                        sync_cnt_d = sync_cnt_q + BURST_W'(1);
                    end
                end
            end
            HOLD: begin
                if (!en_i) begin
                    sub_cnt_d  = '0;
                    s_sh_d     = '0;
                    b_sh_d     = '0;
                    sub_idx_d  = '0;
                    sync_cnt_d = '0;
                end
            end
            default: begin
                sub_cnt_d  = '0;
                s_sh_d     = '0;
                b_sh_d     = '0;
                sub_idx_d  = '0;
                sync_cnt_d = '0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_cnt_q  <= '0;
            s_sh_q     <= '0;
            b_sh_q     <= '0;
            sub_idx_q  <= '0;
            sync_cnt_q <= '0;
            start_q    <= 1'b0;
        end else begin
            sub_cnt_q  <= sub_cnt_d;
            s_sh_q     <= s_sh_d;
            b_sh_q     <= b_sh_d;
            sub_idx_q  <= sub_idx_d;
            sync_cnt_q <= sync_cnt_d;
            start_q    <= start_d;
        end
    end

endmodule
